ro_scan_sequencer: RTL and testbench
====================================

// Module: ro_scan_sequencer
// PURPOSE
//  - Drive side of the RO sensor array: enables one ring oscillator at a time (one-hot, 1:N), drives the
//    11-bit index into the N:1 RO mux, and counts edges of the returned mux output over a fixed window.
//  - Emits one {index, count} record per RO over a valid/ready stream to the logging/host path.
//  - Sweeps RO 0..NWAY-1; stops after one sweep, or wraps to RO 0 in continuous mode.
// PARAMETERS
//  NWAY        5     number of ring oscillators (1..2047)
//  CNT_W       32    width of the edge counter and the count output
//  SETTLE_CYC  16    clk cycles after enabling an RO before counting starts (>=1)
//  WINDOW_CYC  1024  clk cycles in the counting window (>=1)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous active-high reset
//  start        in   1      single-cycle pulse: begin a sweep at RO 0 (ignored while busy)
//  continuous   in   1      1 = wrap to RO 0 after RO NWAY-1; sampled at the end of each record
//  ro_en        out  NWAY   one-hot RO enable; all zero when idle
//  select       out  11     index of the active RO into the N:1 mux
//  ro_selected  in   1      mux output, asynchronous to clk (pre-divided below clk/2)
//  busy         out  1      high from start accept until return to IDLE
//  rec_idx      out  11     RO index of the current record
//  rec_count    out  CNT_W  edge count of the current record
//  rec_valid    out  1      record available
//  rec_ready    in   1      consumer accepts record when rec_valid & rec_ready
// BEHAVIOUR
//  - Reset: state IDLE; ro_en=0, select=0, busy=0, rec_valid=0, rec_idx=0, rec_count=0; counters and sync flops 0.
//  - ro_selected passes through a 2-flop synchronizer, then a rising-edge detector (3rd flop); edge latency 3 clk.
//  - FSM: IDLE -> SETTLE -> MEASURE -> OUTPUT -> (SETTLE | IDLE).
//    IDLE:    start=1 -> idx=0, ro_en=1<<0, select=0, busy=1, settle counter=0, go SETTLE.
//    SETTLE:  ro_en/select held; after SETTLE_CYC cycles clear edge counter, go MEASURE.
//    MEASURE: exactly WINDOW_CYC cycles; each detected rising edge increments count; then go OUTPUT.
//             Count saturates at 2^CNT_W-1 (no wrap).
//    OUTPUT:  on entry rec_idx=idx, rec_count=count, rec_valid=1; ro_en=0 (RO off for cooling/isolation).
//             rec_valid, rec_idx, rec_count stable until handshake. On rec_valid & rec_ready:
//             rec_valid=0 next cycle; if idx<NWAY-1: idx+1, enable it, go SETTLE;
//             else if continuous: idx=0, go SETTLE; else busy=0, select=0, go IDLE.
//  - Per-RO record period with rec_ready tied high: SETTLE_CYC + WINDOW_CYC + 1 clk.
//  - Edges detected during SETTLE or OUTPUT are discarded; synchronizer keeps running in all states.
//  - Backpressure: OUTPUT stalls indefinitely with rec_ready=0; no record dropped or overwritten.
//  - start while busy: ignored (no restart, no queueing). start with continuous=1 in IDLE behaves identically.
//  - continuous dropped mid-sweep: current sweep finishes to RO NWAY-1, then IDLE.
//  - ro_en is always one-hot or zero; ro_en[select]=1 whenever state is SETTLE or MEASURE.
//  - rst mid-operation: all outputs return to reset values immediately (async); partial record discarded.
//  - select zero-extended from clog2(NWAY) bits to 11 bits; upper bits always 0.
// STRUCTURE
//  - Shared package ro_sensor_pkg: state enum {IDLE,SETTLE,MEASURE,OUTPUT}, SEL_W=11 constant,
//    record struct {idx[10:0], count[CNT_W-1:0]} for reuse by the logger.
//  - One sub-module: ro_edge_sync (2-flop sync + rising-edge detect, async-reset, output 1-clk pulse).
//  - FSM, settle/window counter (shared, width clog2(max(SETTLE_CYC,WINDOW_CYC))+1), edge counter,
//    index register and one-hot decoder in this module.
// TESTING
//  1 Reset: assert rst mid-MEASURE -> ro_en=0, busy=0, rec_valid=0 same cycle; no record after release.
//  2 Single sweep, NWAY=5, SETTLE=16, WINDOW=1024, ro_selected toggling every 8 clk (period 16), ready=1
//    -> 5 records idx 0..4, count 64 each (+-1), spaced 1041 clk; busy falls after idx 4; ro_en one-hot throughout.
//  3 Backpressure: rec_ready=0 for 500 clk on idx 2 -> rec_valid/idx/count stable, ro_en=0, no idx 3 enable until accept.
//  4 Continuous=1, ready=1 -> records idx 4 then 0 back-to-back; drop continuous during idx 1 -> ends after idx 4.
//  5 Edge gating: ro_selected toggles only during SETTLE -> count 0; start pulsed while busy -> ignored.
//  6 Saturation: CNT_W=4, 40 edges in window -> rec_count=15.

Source files
------------

// File: rtl/ro_sensor_pkg.sv
// Shared types for the RO sensor array: sequencer state, mux select width and
// the {index, count} record handed to the logger.
package ro_sensor_pkg;
  localparam int SEL_W     = 11;
  localparam int REC_CNT_W = 32;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, OUTPUT} ro_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]     idx;
    logic [REC_CNT_W-1:0] count;
  } ro_rec_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous RO mux output into the clk domain and emits a
// one-cycle pulse per rising edge.
module ro_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], i_async};
  end

  assign o_rise = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/ro_scan_sequencer.sv
// Sweeps the ring oscillators one at a time: enable, settle, count edges over a
// fixed window, then hand off an {index, count} record over valid/ready.
module ro_scan_sequencer
  import ro_sensor_pkg::*;
#(
  parameter int NWAY       = 5,
  parameter int CNT_W      = 32,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic [NWAY-1:0]   ro_en,
  output logic [SEL_W-1:0]  select,
  input  logic              ro_selected,
  output logic              busy,
  output logic [SEL_W-1:0]  rec_idx,
  output logic [CNT_W-1:0]  rec_count,
  output logic              rec_valid,
  input  logic              rec_ready
);
  localparam int IW = (NWAY > 1) ? $clog2(NWAY) : 1;
  localparam int TW = $clog2(max2(SETTLE_CYC, WINDOW_CYC)) + 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NWAY - 1);

  ro_state_e        r_state, w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic             r_ro_on, r_busy, r_rec_valid;
  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_edges, w_edges_nxt, r_rec_count;
  logic [SEL_W-1:0] r_rec_idx;
  logic             w_rise;
  logic             w_accept, w_settle_done, w_window_done, w_advance, w_wrap, w_finish;

  ro_edge_sync u_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(ro_selected),
    .o_rise (w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_settle_done = 1'b0;
    w_window_done = 1'b0;
    w_advance     = 1'b0;
    w_wrap        = 1'b0;
    w_finish      = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = SETTLE;
      end
      SETTLE: if (r_tmr == SETTLE_LAST) begin
        w_settle_done = 1'b1;
        w_state_nxt   = MEASURE;
      end
      MEASURE: if (r_tmr == WINDOW_LAST) begin
        w_window_done = 1'b1;
        w_state_nxt   = OUTPUT;
      end
      OUTPUT: if (rec_ready) begin
        if (r_idx != IDX_LAST) begin
          w_advance   = 1'b1;
          w_state_nxt = SETTLE;
        end else if (continuous) begin
          w_wrap      = 1'b1;
          w_state_nxt = SETTLE;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Saturating so a fast RO or a narrow counter pins at all-ones instead of wrapping.
  assign w_edges_nxt = (w_rise && (r_edges != {CNT_W{1'b1}})) ? r_edges + CNT_W'(1) : r_edges;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_ro_on     <= 1'b0;
      r_busy      <= 1'b0;
      r_rec_valid <= 1'b0;
      r_tmr       <= '0;
      r_edges     <= '0;
      r_rec_idx   <= '0;
      r_rec_count <= '0;
    end else begin
      if ((r_state == SETTLE || r_state == MEASURE) && !w_settle_done && !w_window_done)
        r_tmr <= r_tmr + TW'(1);
      else
        r_tmr <= '0;

      if (w_settle_done)           r_edges <= '0;
      else if (r_state == MEASURE) r_edges <= w_edges_nxt;

      if (w_accept) begin
        r_idx   <= '0;
        r_ro_on <= 1'b1;
        r_busy  <= 1'b1;
      end
      // RO is switched off while the record waits, so it cools and stops coupling.
      if (w_window_done) begin
        r_ro_on     <= 1'b0;
        r_rec_valid <= 1'b1;
        r_rec_idx   <= SEL_W'(r_idx);
        r_rec_count <= w_edges_nxt;
      end
      if (w_advance) begin
        r_idx       <= r_idx + IW'(1);
        r_ro_on     <= 1'b1;
        r_rec_valid <= 1'b0;
      end
      if (w_wrap) begin
        r_idx       <= '0;
        r_ro_on     <= 1'b1;
        r_rec_valid <= 1'b0;
      end
      if (w_finish) begin
        r_idx       <= '0;
        r_busy      <= 1'b0;
        r_rec_valid <= 1'b0;
      end
    end
  end

  assign ro_en     = r_ro_on ? (NWAY'(1) << r_idx) : '0;
  assign select    = SEL_W'(r_idx);
  assign busy      = r_busy;
  assign rec_valid = r_rec_valid;
  assign rec_idx   = r_rec_idx;
  assign rec_count = r_rec_count;
endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Directed-plus-random bench for the RO scan sequencer: sweep, backpressure,
// continuous wrap, edge gating, reset abort and counter saturation.
module tb_ro_scan_sequencer;
  localparam int NW = 5, SC = 16, WC = 1024, GAP = SC + WC + 1;
  localparam int S_SC = 4, S_WC = 160;

  logic        clk, rst, start, continuous, rec_ready, ro_sel;
  logic [4:0]  ro_en;
  logic [10:0] select, rec_idx;
  logic [31:0] rec_count;
  logic        busy, rec_valid;

  logic        s_start, s_cont, s_ready;
  logic [1:0]  s_ro_en;
  logic [10:0] s_select, s_rec_idx;
  logic [3:0]  s_rec_count;
  logic        s_busy, s_rec_valid;

  int nvec = 0, nerr = 0, cyc = 0;
  int gen_half = 0, gen_stop = 0;

  ro_scan_sequencer #(.NWAY(NW), .CNT_W(32), .SETTLE_CYC(SC), .WINDOW_CYC(WC)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ro_en(ro_en),
    .select(select), .ro_selected(ro_sel), .busy(busy), .rec_idx(rec_idx),
    .rec_count(rec_count), .rec_valid(rec_valid), .rec_ready(rec_ready));

  ro_scan_sequencer #(.NWAY(2), .CNT_W(4), .SETTLE_CYC(S_SC), .WINDOW_CYC(S_WC)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .continuous(s_cont), .ro_en(s_ro_en),
    .select(s_select), .ro_selected(ro_sel), .busy(s_busy), .rec_idx(s_rec_idx),
    .rec_count(s_rec_count), .rec_valid(s_rec_valid), .rec_ready(s_ready));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RO stand-in: square wave with half-period gen_half clk, held low when stopped.
  initial begin
    int gcnt;
    ro_sel = 0;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_half != 0 && cyc < gen_stop) begin
        gcnt++;
        if (gcnt >= gen_half) begin
          gcnt = 0;
          ro_sel = ~ro_sel;
        end
      end else begin
        gcnt = 0;
        ro_sel = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      nvec++;
      assert (((ro_en === 5'd0) || (ro_en === (5'd1 << select))) &&
              (!rec_valid || ro_en === 5'd0) && (ro_en === 5'd0 || busy === 1'b1))
      else begin
        nerr++;
        $error("FAIL onehot obs=ro_en %b sel %0d valid %b busy %b exp=onehot matching select", ro_en, select, rec_valid, busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_rec(input bit sat, output int idx, output longint cnt, output int t);
    int n;
    n = 0;
    while (!(sat ? s_rec_valid : rec_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("rec_timeout", 64'(n < 3000), 64'd1);
    idx = sat ? int'(s_rec_idx) : int'(rec_idx);
    cnt = sat ? longint'(s_rec_count) : longint'(rec_count);
    t   = cyc;
  endtask

  // per = RO period in clk (0: no edges expected). Count must be W/per within one edge.
  task automatic get_rec(input int exp_idx, input int per, input bit chk_gap, input int t_prev, output int t_now);
    int idx;
    longint cnt, diff;
    wait_rec(0, idx, cnt, t_now);
    chk("rec_idx", 64'(idx), 64'(exp_idx));
    if (per == 0) chk("rec_count_zero", 64'(cnt), 64'd0);
    else begin
      diff = cnt * per - WC;
      chk("rec_count_tol", 64'(diff <= per && diff >= -per), 64'd1);
    end
    if (chk_gap) chk("rec_gap", 64'(t_now - t_prev), 64'(GAP));
  endtask

  initial begin
    int tp, h, stall, idx0;
    int q[$];
    bit ok;
    longint c0;

    rst = 1; start = 0; continuous = 0; rec_ready = 1;
    s_start = 0; s_cont = 0; s_ready = 1;
    tp = 0;
    tick(2);
    chk("rst_ro_en", 64'(ro_en), 64'd0);
    chk("rst_select", 64'(select), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec_idx", 64'(rec_idx), 64'd0);
    chk("rst_rec_count", 64'(rec_count), 64'd0);
    chk("rst_s_busy", 64'(s_busy), 64'd0);
    rst = 0;
    tick(1);

    // Reset abort in the middle of a window.
    gen_half = 4; gen_stop = 32'h7fffffff;
    pulse_start();
    tick(100);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_ro_en", 64'(ro_en), 64'd1);
    #2 rst = 1;
    #1;
    chk("abort_ro_en", 64'(ro_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(rec_valid), 64'd0);
    tick(2);
    rst = 0;
    tick(1200);
    chk("abort_no_rec", 64'(rec_valid), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    // Single sweep, random RO period, with a stray start while busy.
    h = $urandom_range(4, 12);
    gen_half = h;
    pulse_start();
    for (int k = 0; k < NW; k++) begin
      get_rec(k, 2 * h, k > 0, tp, tp);
      tick(1);
      if (k == 1) pulse_start();
    end
    chk("sweep_busy_end", 64'(busy), 64'd0);
    chk("sweep_sel_end", 64'(select), 64'd0);
    chk("sweep_ro_en_end", 64'(ro_en), 64'd0);

    // Backpressure on idx 2 for a random number of cycles.
    h = $urandom_range(3, 10);
    gen_half = h;
    pulse_start();
    for (int k = 0; k < NW; k++) begin
      get_rec(k, 2 * h, k > 0 && k != 3, tp, tp);
      if (k == 2) begin
        c0 = longint'(rec_count);
        ok = 1;
        stall = $urandom_range(400, 600);
        for (int i = 0; i < stall; i++) begin
          tick(1);
          if (!(rec_valid === 1'b1 && rec_idx === 11'd2 && longint'(rec_count) == c0 && ro_en === 5'd0))
            ok = 0;
        end
        chk("bp_stable", 64'(ok), 64'd1);
        rec_ready = 1;
        tick(1);
        chk("bp_next_en", 64'(ro_en), 64'b01000);
        chk("bp_valid_drop", 64'(rec_valid), 64'd0);
      end else begin
        tick(1);
        if (k == 1) rec_ready = 0;
      end
    end
    chk("bp_busy_end", 64'(busy), 64'd0);

    // Continuous mode: wrap 4 -> 0 back-to-back, drop continuous while RO 1 runs.
    h = $urandom_range(4, 12);
    gen_half = h;
    continuous = 1;
    for (int r = 0; r < 2; r++) for (int k = 0; k < NW; k++) q.push_back(k);
    pulse_start();
    for (int j = 0; j < q.size(); j++) begin
      get_rec(q[j], 2 * h, j > 0, tp, tp);
      tick(1);
      if (j == NW) continuous = 0;
      if (j == NW - 1) chk("cont_still_busy", 64'(busy), 64'd1);
    end
    chk("cont_busy_end", 64'(busy), 64'd0);

    // Edges only during SETTLE are discarded; start while busy is ignored.
    gen_half = 0;
    tick(4);
    pulse_start();
    for (int k = 0; k < NW; k++) begin
      gen_half = 1;
      gen_stop = cyc + 6;
      if (k == 2) begin
        tick(200);
        pulse_start();
      end
      get_rec(k, 0, 1'b0, tp, tp);
      gen_half = 0;
      tick(1);
    end
    chk("gate_busy_end", 64'(busy), 64'd0);

    // Saturation on the 4-bit instance: 40 edges per window.
    gen_half = 2;
    gen_stop = 32'h7fffffff;
    s_start = 1;
    tick(1);
    s_start = 0;
    for (int k = 0; k < 2; k++) begin
      wait_rec(1, idx0, c0, tp);
      chk("sat_idx", 64'(idx0), 64'(k));
      chk("sat_count", 64'(c0), 64'd15);
      tick(1);
    end
    chk("sat_busy_end", 64'(s_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
